// File: rtl/uart_apb_stream_master.sv
// uart_apb_stream_master
//   APB master standing in for a CPU in front of a CoreUARTapb slave. After
//   reset it programs the baud/control registers, then loops polling the
//   status register: queued TX bytes are written to the TX data register and
//   received bytes are pulled into a one-entry holding register that drives a
//   valid/ready output stream.
//
//   Optional feature macro: UART_STRM_RX_EN. When undefined the RX read path
//   and holding register are removed; rx_valid/rx_data are tied to 0.
//
// Ports
//   PCLK, aresetn              clock, async active-low reset
//   tx_data/tx_valid/tx_ready  inbound byte stream (UART transmit)
//   rx_data/rx_valid/rx_ready  outbound byte stream (UART receive)
//   err_clr, err_flags         sticky {FRAMING, OVERFLOW, PARITY} + clear
//   cfg_done                   init register writes complete
//   PADDR..PSLVERR             APB master port (PSLVERR ignored)
module uart_apb_stream_master #(
  parameter logic [12:0] BAUD_VALUE = 13'd0,
  parameter logic        BIT8       = 1'b1,
  parameter logic        PARITY_EN  = 1'b0,
  parameter logic        ODD_N_EVEN = 1'b0,
  parameter int unsigned POLL_GAP   = 4
) (
  input  logic       PCLK,
  input  logic       aresetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       err_clr,
  output logic [2:0] err_flags,
  output logic       cfg_done,
  output logic [4:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR
);

  localparam logic [4:0] A_TX   = 5'h00;
  localparam logic [4:0] A_RX   = 5'h04;
  localparam logic [4:0] A_BAUD = 5'h08;
  localparam logic [4:0] A_CTRL = 5'h0C;
  localparam logic [4:0] A_STAT = 5'h10;

  localparam logic [7:0] CTRL_VAL = {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
  localparam logic [7:0] GAP_LOAD = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    INIT_C1, INIT_C2, POLL, WR_TX, GAP
`ifdef UART_STRM_RX_EN
    , RD_RX
`endif
  } state_t;

  typedef struct packed {
    logic [4:0] addr;
    logic       write;
    logic [7:0] wdata;
  } apb_req_t;

  state_t     state, nxt;
  logic       launch;
  apb_req_t   req;
  logic [7:0] gap_cnt;
  logic       done, rx_go, tx_go;

  // Setup-phase fields for the transfer a given state performs.
  function automatic apb_req_t req_of(input state_t s, input logic [7:0] txd);
    apb_req_t r;
    r.addr  = A_STAT;
    r.write = 1'b0;
    r.wdata = 8'h00;
    case (s)
      INIT_C1: begin r.addr = A_BAUD; r.write = 1'b1; r.wdata = BAUD_VALUE[7:0]; end
      INIT_C2: begin r.addr = A_CTRL; r.write = 1'b1; r.wdata = CTRL_VAL;        end
      WR_TX:   begin r.addr = A_TX;   r.write = 1'b1; r.wdata = txd;             end
`ifdef UART_STRM_RX_EN
      RD_RX:   begin r.addr = A_RX; end
`endif
      default: ;
    endcase
    return r;
  endfunction

  assign done     = PSEL & PENABLE & PREADY;
  // Combinational so the pulse lands on the completing ACCESS cycle itself.
  assign tx_ready = done & (state == WR_TX);
  assign tx_go    = tx_valid & PRDATA[0];

`ifdef UART_STRM_RX_EN
  // Only read RX data when there is somewhere to put it; the UART keeps
  // RXRDY asserted so the read is simply retried on a later poll.
  assign rx_go = PRDATA[1] & ~rx_valid;
`else
  assign rx_go    = 1'b0;
  assign rx_valid = 1'b0;
  assign rx_data  = 8'h00;
`endif

  // launch = issue a SETUP cycle on this edge for state nxt. Completion of
  // one transfer launches the next directly (back-to-back, no idle cycle);
  // only the POLL->GAP decision drops PSEL.
  always_comb begin
    nxt    = state;
    launch = 1'b0;
    case (state)
      GAP: if (gap_cnt == 8'd0) begin nxt = POLL; launch = 1'b1; end
      default: begin
        if (!PSEL) launch = 1'b1;
        else if (done) begin
          launch = 1'b1;
          case (state)
            INIT_C1: nxt = INIT_C2;
            INIT_C2: nxt = POLL;
            POLL: begin
              if (rx_go)              nxt = state_t'(3'd5);
              else if (tx_go)         nxt = WR_TX;
              else if (POLL_GAP != 0) begin nxt = GAP; launch = 1'b0; end
              else                    nxt = POLL;
            end
            default: nxt = POLL;  // WR_TX / RD_RX: always re-poll, never reuse status
          endcase
        end
      end
    endcase
    req = req_of(nxt, tx_data);
  end

  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) begin
      state     <= INIT_C1;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      gap_cnt   <= '0;
      cfg_done  <= 1'b0;
      err_flags <= '0;
    end else begin
      state <= nxt;
      if (launch) begin
        PSEL    <= 1'b1;
        PENABLE <= 1'b0;
        PADDR   <= req.addr;
        PWRITE  <= req.write;
        PWDATA  <= req.wdata;
      end else if (PSEL && !PENABLE) begin
        PENABLE <= 1'b1;
      end else if (done) begin
        PSEL    <= 1'b0;
        PENABLE <= 1'b0;
      end

      if (state == POLL && nxt == GAP) gap_cnt <= GAP_LOAD;
      else if (state == GAP)           gap_cnt <= gap_cnt - 8'd1;

      if (done && state == INIT_C2) cfg_done <= 1'b1;

      // Set from the status read wins over a same-cycle clear.
      err_flags <= (err_clr ? 3'b000 : err_flags) |
                   ((done && state == POLL) ? PRDATA[4:2] : 3'b000);
    end
  end

`ifdef UART_STRM_RX_EN
  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (done && state == RD_RX) begin
      rx_valid <= 1'b1;
      rx_data  <= PRDATA;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end
`endif

  logic unused_ok;
  assign unused_ok = ^{PSLVERR, rx_ready, PRDATA};

endmodule

// File: tb/tb_uart_apb_stream_master.sv
module tb_uart_apb_stream_master;

  logic       PCLK = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [2:0] err_flags;
  logic       cfg_done;
  logic [4:0] PADDR;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PWDATA, PRDATA;
  logic       PREADY = 1'b1;
  logic       PSLVERR = 1'b0;

  logic [7:0] stat = 8'h00;
  logic [7:0] rx_byte = 8'h00;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int txr_cnt = 0;

  typedef struct { logic [4:0] addr; logic wr; logic [7:0] data; int cyc; } xfer_t;
  xfer_t q[$];

  always #5 PCLK = ~PCLK;

  // Simple UART register responder.
  assign PRDATA = (PADDR == 5'h10) ? stat : (PADDR == 5'h04) ? rx_byte : 8'h00;

  uart_apb_stream_master #(
    .BAUD_VALUE(13'h145), .BIT8(1'b1), .PARITY_EN(1'b1), .ODD_N_EVEN(1'b0), .POLL_GAP(4)
  ) dut (
    .PCLK(PCLK), .aresetn(aresetn),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .err_clr(err_clr), .err_flags(err_flags), .cfg_done(cfg_done),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Transfer log: every completed APB transfer and every tx_ready pulse.
  always @(posedge PCLK) begin
    xfer_t x;
    cyc = cyc + 1;
    if (aresetn && PSEL && PENABLE && PREADY) begin
      x.addr = PADDR; x.wr = PWRITE; x.data = PWDATA; x.cyc = cyc;
      q.push_back(x);
    end
    if (tx_ready) txr_cnt = txr_cnt + 1;
  end

  function automatic int count_addr(input int from, input logic [4:0] a);
    int n = 0;
    for (int i = from; i < q.size(); i++) if (q[i].addr == a) n++;
    return n;
  endfunction

  task automatic wait_poll_setup(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge PCLK);
      if (PSEL && !PENABLE && PADDR == 5'h10) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== 16'h0)
      $display("FAIL reset_apb: got %b/%b/%b %h %h, want all 0", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    else passes++;
    checks++;
    if ({tx_ready, rx_valid, rx_data, err_flags, cfg_done} !== 14'h0)
      $display("FAIL reset_stream: got txr=%b rxv=%b rxd=%h err=%b cfg=%b, want 0",
               tx_ready, rx_valid, rx_data, err_flags, cfg_done);
    else passes++;
  endtask

  task automatic test_config();
    aresetn = 1'b1;
    @(negedge PCLK);  // cycle 1
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 5'h08, 8'h45})
      $display("FAIL cfg_c1_setup: got %b%b%b %h %h, want 101 08 45", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    else passes++;
    @(negedge PCLK);  // cycle 2
    checks++;
    if ({PSEL, PENABLE, PADDR} !== {2'b11, 5'h08})
      $display("FAIL cfg_c1_access: got %b%b %h, want 11 08", PSEL, PENABLE, PADDR);
    else passes++;
    @(negedge PCLK);  // cycle 3
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 5'h0C, 8'h0B})
      $display("FAIL cfg_c2_setup: got %b%b%b %h %h, want 101 0c 0b", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    else passes++;
    @(negedge PCLK);  // cycle 4
    checks++;
    if (cfg_done !== 1'b0) $display("FAIL cfg_done_early: got %b want 0", cfg_done);
    else passes++;
    @(negedge PCLK);  // cycle 5
    checks++;
    if ({cfg_done, PSEL, PENABLE, PWRITE, PADDR} !== {4'b1100, 5'h10})
      $display("FAIL cfg_done_c5: got cfg=%b %b%b%b %h, want 1 100 10", cfg_done, PSEL, PENABLE, PWRITE, PADDR);
    else passes++;
  endtask

  task automatic test_tx_blocked();
    int base, t0;
    bit period_ok;
    stat = 8'h00; tx_data = 8'hA5; tx_valid = 1'b1;
    base = q.size(); t0 = txr_cnt;
    repeat (26) @(negedge PCLK);
    checks++;
    if (count_addr(base, 5'h00) !== 0) $display("FAIL blocked_nowrite: got %0d tx writes, want 0", count_addr(base, 5'h00));
    else passes++;
    checks++;
    if (txr_cnt - t0 !== 0) $display("FAIL blocked_txready: got %0d pulses, want 0", txr_cnt - t0);
    else passes++;
    period_ok = (q.size() - base) >= 3;
    for (int i = base + 1; i < q.size(); i++)
      if (q[i].addr != 5'h10 || q[i].cyc - q[i-1].cyc != 6) period_ok = 1'b0;
    checks++;
    if (!period_ok) $display("FAIL blocked_period: polls=%0d, spacing not 6", q.size() - base);
    else passes++;
  endtask

  task automatic test_tx_send();
    int base, t0, nwr;
    bit seen = 1'b0;
    base = q.size(); t0 = txr_cnt;
    stat = 8'h01;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge PCLK);
      if (tx_ready) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL tx_send_timeout: got no tx_ready, want pulse");
    else passes++;
    @(posedge PCLK); #1;
    tx_valid = 1'b0; stat = 8'h00;
    @(negedge PCLK);
    checks++;
    if (tx_ready !== 1'b0) $display("FAIL tx_ready_width: got %b after pulse, want 0", tx_ready);
    else passes++;
    repeat (12) @(negedge PCLK);
    checks++;
    if (txr_cnt - t0 !== 1) $display("FAIL tx_ready_pulses: got %0d, want 1", txr_cnt - t0);
    else passes++;
    nwr = 0;
    for (int i = base; i < q.size(); i++) if (q[i].addr == 5'h00 && q[i].wr && q[i].data == 8'hA5) nwr++;
    checks++;
    if (nwr !== 1 || count_addr(base, 5'h00) !== 1)
      $display("FAIL tx_write: got %0d writes of a5 (%0d total), want 1", nwr, count_addr(base, 5'h00));
    else passes++;
  endtask

`ifdef UART_STRM_RX_EN
  task automatic test_rx();
    int base, i04, i00;
    bit seen = 1'b0;
    base = q.size();
    stat = 8'h03; rx_byte = 8'h3C; tx_data = 8'h5A; tx_valid = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge PCLK);
      if (tx_ready) seen = 1'b1;
    end
    @(posedge PCLK); #1;
    tx_valid = 1'b0;
    i04 = -1; i00 = -1;
    for (int i = base; i < q.size(); i++) begin
      if (q[i].addr == 5'h04 && i04 < 0) i04 = i;
      if (q[i].addr == 5'h00 && i00 < 0) i00 = i;
    end
    checks++;
    if (!seen || i04 < 0 || i00 < 0 || i04 > i00)
      $display("FAIL rx_priority: got rd_idx=%0d wr_idx=%0d seen=%b, want rd before wr", i04, i00, seen);
    else passes++;
    checks++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h3C})
      $display("FAIL rx_data: got v=%b d=%h, want 1 3c", rx_valid, rx_data);
    else passes++;
    repeat (20) @(negedge PCLK);
    checks++;
    if (count_addr(base, 5'h04) !== 1) $display("FAIL rx_full_noread: got %0d reads, want 1", count_addr(base, 5'h04));
    else passes++;
    rx_byte = 8'h77; rx_ready = 1'b1;
    @(posedge PCLK); #1;
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) $display("FAIL rx_valid_clear: got %b, want 0", rx_valid);
    else passes++;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge PCLK);
      if (rx_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || rx_data !== 8'h77) $display("FAIL rx_second: got v=%b d=%h, want 1 77", seen, rx_data);
    else passes++;
    stat = 8'h00; rx_ready = 1'b1;
    @(posedge PCLK); #1;
    rx_ready = 1'b0;
  endtask
`else
  task automatic test_rx_disabled();
    int base;
    base = q.size();
    stat = 8'h02; rx_byte = 8'h3C; rx_ready = 1'b1;
    repeat (20) @(negedge PCLK);
    checks++;
    if (count_addr(base, 5'h04) !== 0 || {rx_valid, rx_data} !== 9'h0)
      $display("FAIL rx_disabled: got %0d reads v=%b d=%h, want 0", count_addr(base, 5'h04), rx_valid, rx_data);
    else passes++;
    stat = 8'h00; rx_ready = 1'b0;
  endtask
`endif

  task automatic test_wait_err();
    bit ok;
    wait_poll_setup(ok);
    checks++;
    if (!ok) $display("FAIL wait_setup_timeout: got no poll setup, want one");
    else passes++;
    PREADY = 1'b0; stat = 8'h1C;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      checks++;
      if ({PSEL, PENABLE, PADDR} !== {2'b11, 5'h10})
        $display("FAIL wait_hold%0d: got %b%b %h, want 11 10", i, PSEL, PENABLE, PADDR);
      else passes++;
    end
    PREADY = 1'b1;
    @(negedge PCLK);
    checks++;
    if (err_flags !== 3'b111 || PSEL !== 1'b0)
      $display("FAIL err_set: got err=%b psel=%b, want 111 0", err_flags, PSEL);
    else passes++;
    stat = 8'h00;
    repeat (12) @(negedge PCLK);
    checks++;
    if (err_flags !== 3'b111) $display("FAIL err_sticky: got %b, want 111", err_flags);
    else passes++;
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
    checks++;
    if (err_flags !== 3'b000) $display("FAIL err_clear: got %b, want 000", err_flags);
    else passes++;
    err_clr = 1'b1; stat = 8'h04;
    wait_poll_setup(ok);
    repeat (2) @(negedge PCLK);
    checks++;
    if (!ok || err_flags !== 3'b001) $display("FAIL err_set_wins: got %b, want 001", err_flags);
    else passes++;
    err_clr = 1'b1; stat = 8'h00;
    @(negedge PCLK);
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok = 1'b0;
    stat = 8'h01; tx_data = 8'h99; tx_valid = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE && PADDR == 5'h00) ok = 1'b1;
    end
    base = q.size();
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (!ok || PSEL !== 1'b0 || tx_ready !== 1'b0)
      $display("FAIL rst_mid_drop: got psel=%b txr=%b found=%b, want 0 0 1", PSEL, tx_ready, ok);
    else passes++;
    @(negedge PCLK);
    checks++;
    if (cfg_done !== 1'b0) $display("FAIL rst_mid_cfg: got %b, want 0", cfg_done);
    else passes++;
    tx_valid = 1'b0; stat = 8'h00;
    aresetn = 1'b1;
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 5'h08, 8'h45} || count_addr(base, 5'h00) !== 0)
      $display("FAIL rst_mid_reinit: got %b%b%b %h %h, want 101 08 45", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_config();
    test_tx_blocked();
    test_tx_send();
`ifdef UART_STRM_RX_EN
    test_rx();
`else
    test_rx_disabled();
`endif
    test_wait_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_apb_stream_master.md
# uart_apb_stream_master

APB master that drives the CoreUARTapb register interface from byte streams. After reset it programs the UART control registers. It then polls the status register, writes queued transmit bytes to the TX data register, and reads received bytes into a single-entry holding register. Those bytes are presented on a valid/ready output stream. It sits directly upstream of the UART's APB slave port, in place of a CPU, for hardware-only serial links.

## Interface
- BAUD_VALUE, 13'd0: 13-bit baud divisor programmed at init.
- BIT8, 1: data width, 1 = 8 bits, 0 = 7 bits.
- PARITY_EN, 0: parity enable.
- ODD_N_EVEN, 0: 1 = odd parity, 0 = even parity.
- POLL_GAP, 4: idle cycles between status polls when no action is taken, range 0–255.
- PCLK  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  tx byte accepted.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data valid.
- rx_ready  in  1  consumer accepts rx_data.
- err_clr  in  1  clears err_flags.
- err_flags  out  3  sticky flags {FRAMING, OVERFLOW, PARITY}.
- cfg_done  out  1  init writes complete.
- PADDR  out  5  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  8  APB write data.
- PRDATA  in  8  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error, ignored.

## Operation
- Reset values: all outputs 0; state INIT_C1; holding register empty.
- INIT_C1 writes 0x08 ← BAUD_VALUE[7:0].
- INIT_C2 writes 0x0C ← {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8}. After this write cfg_done=1, held until reset.
- POLL reads 0x10. Status bit mapping: [0]=TXRDY, [1]=RXRDY, [2]=PARITY, [3]=OVERFLOW, [4]=FRAMING.
  - err_flags |= {status[4], status[3], status[2]} on every poll.
  - err_clr=1 clears err_flags. A set on the same cycle wins over the clear.
- Decision after POLL, in priority order:
  1. RXRDY=1 and holding register empty → RD_RX.
  2. Else tx_valid=1 and TXRDY=1 → WR_TX.
  3. Else → GAP.
- RX is prioritised over TX to avoid UART overflow.
- RD_RX reads 0x04. PRDATA is captured into the holding register, and rx_valid=1 from the next cycle.
  - rx_valid clears on the cycle after rx_valid & rx_ready.
  - RXRDY=1 with a full holding register → GAP; the RX read is retried on a later poll.
- WR_TX writes 0x00 ← tx_data.
  - tx_ready is a single-cycle pulse on the access cycle that completes with PREADY=1.
  - The handshake completes when tx_valid & tx_ready.
  - tx_valid and tx_data must stay stable until accepted.
- GAP counts POLL_GAP cycles, then goes to POLL. POLL_GAP=0 goes straight to POLL.
- After RD_RX or WR_TX the FSM returns to POLL directly; the stale TXRDY/RXRDY is never reused.
- PSLVERR is ignored.

## Timing
- APB transfer:
  - SETUP cycle: PSEL=1, PENABLE=0, with PADDR/PWRITE/PWDATA valid.
  - ACCESS cycle(s): PSEL=1, PENABLE=1, extended while PREADY=0 with all outputs held.
  - Completion is the ACCESS cycle with PREADY=1; PRDATA is sampled there.
- Minimum 2 cycles per transfer. Back-to-back transfers are allowed: the next SETUP follows completion directly, with no PSEL=0 cycle.
- First SETUP occurs on the first PCLK edge after aresetn deasserts.
- With PREADY=1, cfg_done rises at cycle 5.
- Best-case TX: POLL (2 cycles) + WR_TX (2 cycles) = 4 cycles from tx_valid to tx_ready.
- Best-case RX: rx_valid rises 5 cycles after the poll SETUP.
- Reset asserted mid-operation: all outputs drop to 0 immediately, a pending transfer is abandoned, the holding byte is lost, and the block re-runs INIT_C1.

## Configuration
- UART_STRM_RX_EN defined: RX path as described.
- UART_STRM_RX_EN undefined:
  - The holding register and RD_RX state are removed.
  - RXRDY is ignored; rx_valid=0 and rx_data=0 constantly; rx_ready is unused.
  - Polling, err_flags and the TX path are unchanged.

## Test plan
- Config write: BAUD_VALUE=13'h145, BIT8=1, PARITY_EN=1, ODD_N_EVEN=0 → APB writes 0x08←0x45 then 0x0C←0x0B; cfg_done=1 at cycle 5.
- TX send: tx_valid=1, tx_data=0xA5, poll returns 0x01 → write 0x00←0xA5; tx_ready pulses exactly 1 cycle.
- TX blocked: poll returns 0x00, tx_valid=1, POLL_GAP=4 → status reads repeat every 6 cycles, no write, tx_ready=0.
- RX priority:
  - Poll returns 0x03, rx read returns 0x3C → read of 0x04 precedes the TX write; rx_data=0x3C, rx_valid=1.
  - With rx_ready=0 and RXRDY held 1 → no second 0x04 read until the rx handshake.
- Wait states and errors: PREADY=0 for 3 ACCESS cycles → PSEL/PENABLE/PADDR held. Poll returns 0x1C → err_flags=3'b111, held until err_clr.
- Reset mid-transfer: aresetn low during WR_TX ACCESS → PSEL=0 within the same cycle; after release, the 0x08 write repeats.
